// File: rtl/pc_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC core: walks FETCH/DECODE/EXEC/MEM
// and drives PC, IR, register-file, ALU and memory handshake strobes from the current state.
module pc_ctrl_fsm #(
    parameter int OPW      = 4,
    parameter int MAX_WAIT = 255,
    parameter int WCW      = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] ir_op,
    input  logic           zero_flag,
    input  logic           mem_ready,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic           ir_ld,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           addr_sel,
    output logic           reg_we,
    output logic           wb_sel,
    output logic [2:0]     alu_op,
    output logic           halted,
    output logic           bus_err,
    output logic           illegal
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_LD   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_ST   = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

    // Last count value before a pending request times out.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic logic op_is_alu(input logic [OPW-1:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic op_is_mem(input logic [OPW-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic [2:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            OP_ADD:  return 3'd1;
            OP_SUB:  return 3'd2;
            OP_AND:  return 3'd3;
            OP_OR:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // State and wait-counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= {WCW{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and wait-counter logic; the counter only runs while a request is pending.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = {WCW{1'b0}};
        case (state_q)
            ST_FETCH, ST_MEM: begin
                if (mem_ready) begin
                    state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_DECODE: begin
                if (!op_is_legal(ir_op) || (ir_op == OP_NOP)) begin
                    state_d = ST_FETCH;
                end else if (ir_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_is_mem(ir_op)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        ir_ld    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = 3'd0;
        halted   = 1'b0;
        bus_err  = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_rd = 1'b1;
                    ir_ld  = mem_ready;
                    pc_inc = mem_ready;
                end
                ST_DECODE: begin
                    illegal = !op_is_legal(ir_op);
                end
                ST_EXEC: begin
                    alu_op = alu_code(ir_op);
                    if (op_is_alu(ir_op)) begin
                        reg_we = 1'b1;
                    end else if (ir_op == OP_JMP) begin
                        pc_ld = 1'b1;
                    end else if (ir_op == OP_BEQ) begin
                        pc_ld = zero_flag;
                    end else begin
                        pc_ld = 1'b0;
                    end
                end
                ST_MEM: begin
                    addr_sel = 1'b1;
                    if (ir_op == OP_LD) begin
                        mem_rd = 1'b1;
                        reg_we = mem_ready;
                        wb_sel = mem_ready;
                    end else if (ir_op == OP_ST) begin
                        mem_wr = 1'b1;
                    end else begin
                        addr_sel = 1'b1;
                    end
                end
                ST_HALT:  halted  = 1'b1;
                ST_FAULT: bus_err = 1'b1;
                default:  halted  = 1'b0;
            endcase
        end else begin
            halted  = 1'b0;
            bus_err = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_ctrl_fsm.sv
// Bench for pc_ctrl_fsm: directed scenarios plus random instruction streams, each cycle
// compared against an instruction-level model of the expected strobe sequence.
module tb_pc_ctrl_fsm;

    localparam int OPW = 4;
    localparam int MW  = 4;

    // Expected-vector bit positions (alu_op occupies [5:3]).
    localparam logic [13:0] B_INC = 14'h2000;
    localparam logic [13:0] B_PLD = 14'h1000;
    localparam logic [13:0] B_IRL = 14'h0800;
    localparam logic [13:0] B_RD  = 14'h0400;
    localparam logic [13:0] B_WR  = 14'h0200;
    localparam logic [13:0] B_AS  = 14'h0100;
    localparam logic [13:0] B_WE  = 14'h0080;
    localparam logic [13:0] B_WB  = 14'h0040;
    localparam logic [13:0] B_HLT = 14'h0004;
    localparam logic [13:0] B_ERR = 14'h0002;
    localparam logic [13:0] B_ILL = 14'h0001;

    logic           clock;
    logic           reset;
    logic [OPW-1:0] ir_op;
    logic           zero_flag;
    logic           mem_ready;
    logic           pc_inc, pc_ld, ir_ld, mem_rd, mem_wr, addr_sel, reg_we, wb_sel;
    logic [2:0]     alu_op;
    logic           halted, bus_err, illegal;
    logic [13:0]    obs;

    int          errors = 0;
    int          checks = 0;
    bit          stopped;
    logic [13:0] absorb_exp;

    pc_ctrl_fsm #(.OPW(OPW), .MAX_WAIT(MW), .WCW(8)) dut (
        .clock(clock), .reset(reset), .ir_op(ir_op), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .pc_inc(pc_inc), .pc_ld(pc_ld), .ir_ld(ir_ld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .reg_we(reg_we),
        .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted), .bus_err(bus_err),
        .illegal(illegal)
    );

    assign obs = {pc_inc, pc_ld, ir_ld, mem_rd, mem_wr, addr_sel, reg_we, wb_sel,
                  alu_op, halted, bus_err, illegal};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [OPW-1:0] rop();
        return OPW'($urandom_range(0, 15));
    endfunction

    function automatic logic [13:0] alu_f(input logic [2:0] a);
        return {8'd0, a, 3'd0};
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
    task automatic step(input logic [OPW-1:0] op, input logic z, input logic rdy,
                        input logic [13:0] exp, input string tag);
        ir_op     = op;
        zero_flag = z;
        mem_ready = rdy;
        @(negedge clock);
        check_eq(tag, obs, exp);
        check_eq("invariant", {12'd0, pc_inc & pc_ld, mem_rd & mem_wr}, 14'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("reset_async", obs, 14'd0);
        @(posedge clock);
        #1;
        check_eq("reset_hold", obs, 14'd0);
        reset   = 1'b0;
        stopped = 1'b0;
    endtask

    task automatic absorb(input int n);
        for (int i = 0; i < n; i++) step(rop(), rbit(), rbit(), absorb_exp, "absorb");
    endtask

    // Instruction-level model: fw/mw are wait cycles before mem_ready in FETCH/MEM.
    task automatic run_instr(input logic [OPW-1:0] op, input logic z, input int fw,
                             input int mw, input bit rst_mid);
        logic        legal;
        logic [13:0] exp;
        logic [13:0] req;
        for (int i = 0; i < fw && i < MW; i++) step(rop(), rbit(), 1'b0, B_RD, "fetch_wait");
        if (fw >= MW) begin
            stopped    = 1'b1;
            absorb_exp = B_ERR;
            return;
        end
        step(rop(), rbit(), 1'b1, B_RD | B_IRL | B_INC, "fetch_done");
        legal = (op <= 4'd8) || (op == 4'hF);
        step(op, rbit(), rbit(), legal ? 14'd0 : B_ILL, "decode");
        if (!legal || op == 4'd0) return;
        if (op == 4'hF) begin
            stopped    = 1'b1;
            absorb_exp = B_HLT;
            return;
        end
        if (op >= 4'd1 && op <= 4'd4) exp = B_WE | alu_f(3'(op));
        else if (op == 4'd7)          exp = z ? B_PLD : 14'd0;
        else if (op == 4'd8)          exp = B_PLD;
        else                          exp = 14'd0;
        step(op, z, rbit(), exp, "exec");
        if (op != 4'd5 && op != 4'd6) return;
        req = (op == 4'd5) ? (B_RD | B_AS) : (B_WR | B_AS);
        if (rst_mid) begin
            ir_op     = op;
            mem_ready = 1'b0;
            @(negedge clock);
            check_eq("mem_before_reset", obs, req);
            reset = 1'b1;
            #1;
            check_eq("mid_mem_reset", obs, 14'd0);
            @(posedge clock);
            #1;
            reset = 1'b0;
            return;
        end
        for (int i = 0; i < mw && i < MW; i++) step(op, rbit(), 1'b0, req, "mem_wait");
        if (mw >= MW) begin
            stopped    = 1'b1;
            absorb_exp = B_ERR;
            return;
        end
        step(op, rbit(), 1'b1, (op == 4'd5) ? (req | B_WE | B_WB) : req, "mem_done");
    endtask

    function automatic int rwait();
        return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 5));
    endfunction

    initial begin
        reset     = 1'b1;
        ir_op     = 4'd0;
        zero_flag = 1'b0;
        mem_ready = 1'b0;
        stopped   = 1'b0;
        absorb_exp = 14'd0;
        @(posedge clock);
        #1;
        do_reset();

        repeat (3) run_instr(4'd1, 1'b0, 0, 0, 1'b0);
        run_instr(4'd5, 1'b0, 3, 3, 1'b0);
        run_instr(4'd7, 1'b1, 0, 0, 1'b0);
        run_instr(4'd7, 1'b0, 0, 0, 1'b0);
        run_instr(4'd8, 1'b0, 0, 0, 1'b0);
        run_instr(4'd6, 1'b0, 1, 2, 1'b0);
        run_instr(4'd2, 1'b0, 0, 0, 1'b0);
        run_instr(4'd3, 1'b0, 0, 0, 1'b0);
        run_instr(4'd4, 1'b0, 0, 0, 1'b0);
        run_instr(4'hB, 1'b0, 0, 0, 1'b0);
        run_instr(4'd0, 1'b0, 0, 0, 1'b0);

        run_instr(4'hF, 1'b0, 0, 0, 1'b0);
        absorb(10);
        do_reset();

        run_instr(4'd1, 1'b0, MW, 0, 1'b0);
        absorb(5);
        do_reset();
        run_instr(4'd1, 1'b0, MW - 1, 0, 1'b0);
        run_instr(4'd5, 1'b0, 0, MW, 1'b0);
        absorb(5);
        do_reset();
        run_instr(4'd5, 1'b0, 0, MW - 1, 1'b0);
        run_instr(4'd6, 1'b0, 0, 1, 1'b1);
        run_instr(4'd1, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            run_instr(rop(), rbit(), rwait(), rwait(), $urandom_range(0, 19) == 0);
            if (stopped) begin
                absorb(3);
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_fsm.md
Name: pc_ctrl_fsm

Overview:
- Multi-cycle control unit for the 16-bit RISC core.
- Sequences fetch/decode/execute/memory phases and drives the PC register strobes (pc_inc, pc_ld), IR load, register-file write, ALU op select and memory read/write handshake.
- Sits between the instruction register / ALU flags and the datapath.
- Guarantees pc_inc and pc_ld are never asserted together.

Parameters:
- OPW, 4, opcode width; opcode = ir_op[OPW-1:0], taken from IR[15:12].
- MAX_WAIT, 255, max cycles a memory request may wait for mem_ready before fault.
- WCW, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH state, clears counter and all flags
- ir_op  in  OPW  opcode field of the instruction register
- zero_flag  in  1  ALU zero result, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- pc_inc  out  1  PC increment strobe
- pc_ld  out  1  PC load-from-alu_out strobe
- ir_ld  out  1  instruction register load strobe
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- addr_sel  out  1  memory address: 0 = PC, 1 = alu_out
- reg_we  out  1  register file write enable
- wb_sel  out  1  writeback source: 0 = ALU, 1 = memory data
- alu_op  out  3  0 pass/add-offset, 1 add, 2 sub, 3 and, 4 or
- halted  out  1  high in HALT
- bus_err  out  1  high in FAULT
- illegal  out  1  one-cycle pulse in DECODE on an undefined opcode

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, HALT, FAULT.
- Reset: state=FETCH, wait counter=0, all outputs 0 except those FETCH drives combinationally (mem_rd=1, addr_sel=0) once reset deasserts. Reset mid-transaction drops any request immediately; the first fetch starts the cycle after deassertion.
- Outputs are combinational from state, ir_op, zero_flag and mem_ready.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LD, 6 ST, 7 BEQ, 8 JMP, F HALT. All others are illegal: `illegal` pulses and the instruction executes as NOP.
- FETCH:
  - mem_rd=1, addr_sel=0, held until mem_ready.
  - On mem_ready, same cycle: ir_ld=1, pc_inc=1, then go to DECODE.
- DECODE: 1 cycle, no strobes.
  - NOP / illegal -> FETCH.
  - HALT -> HALT.
  - All others -> EXEC.
- EXEC (1 cycle):
  - ADD/SUB/AND/OR: alu_op=1/2/3/4, reg_we=1, wb_sel=0, -> FETCH.
  - LD/ST: alu_op=0 (address calc), -> MEM.
  - JMP: alu_op=0, pc_ld=1, -> FETCH.
  - BEQ: alu_op=0; pc_ld=zero_flag; -> FETCH.
- MEM:
  - LD: mem_rd=1, addr_sel=1, held; on mem_ready: reg_we=1, wb_sel=1, -> FETCH.
  - ST: mem_wr=1, addr_sel=1, held; on mem_ready -> FETCH.
  - ir_op must stay stable through MEM; IR is not loaded outside FETCH.
- Wait counter:
  - Clears on entry to FETCH/MEM and on every mem_ready.
  - Increments each cycle a request is pending without mem_ready.
  - When it reaches MAX_WAIT with mem_ready still low -> FAULT. No strobes are issued for the timed-out transfer, and the PC does not advance.
  - mem_ready in the same cycle the count reaches MAX_WAIT completes normally (ready wins).
- HALT / FAULT: absorbing; all strobes 0; halted or bus_err=1; exit only via reset.
- Invariants:
  - pc_inc & pc_ld == 0 always.
  - mem_rd & mem_wr == 0 always.
  - Strobes last exactly one cycle per instruction.
- mem_ready outside FETCH/MEM is ignored.
- Min cycles per instruction (zero-wait memory):
  - ALU / JMP / BEQ = 3.
  - LD / ST = 4.
  - NOP = 2.

Test Plan:
- Reset, mem_ready tied 1, ir_op=1 (ADD) -> cycle sequence FETCH(ir_ld, pc_inc) / DECODE / EXEC(reg_we, alu_op=1); repeats every 3 cycles, pc_inc once per 3 cycles.
- ir_op=5 (LD), mem_ready low for 3 cycles in both FETCH and MEM -> mem_rd held 4 cycles each phase; addr_sel 0 then 1; reg_we & wb_sel=1 only on the MEM ready cycle.
- ir_op=7 (BEQ) with zero_flag=1 then 0 -> pc_ld=1 in EXEC for the first, 0 for the second; pc_inc never coincides with pc_ld.
- ir_op=F -> halted=1 after DECODE; 10 further cycles with mem_ready toggling give no strobes. Reset returns to FETCH.
- mem_ready held low in FETCH, MAX_WAIT=4 -> bus_err=1 after 4 wait cycles, no pc_inc. Repeat with mem_ready arriving on the 4th cycle -> normal completion.
- Assert reset mid-MEM of an ST -> mem_wr drops immediately (async); fetch restarts with addr_sel=0 after deassertion. ir_op=0xB -> illegal pulses 1 cycle, behaves as NOP.
